mul4_fitness_scorer: RTL and testbench

//  Sequential fitness stage that sits directly downstream of the evolved bit-sliced 2x2 multiplier

---
 rtl/mul4_fitness_scorer.sv | 149 ++++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer for evolved 2x2 multiplier candidates.
// Per beat, each lane compares the candidate's y3..y0 against the golden
// product of {a1,a0} x {b1,b0}; matches are accumulated over NUM_BEATS beats.

// Per-lane golden product and bitwise match against the candidate output.
module mul4_fitness_lane (
  input  logic       i_a1,
  input  logic       i_a0,
  input  logic       i_b1,
  input  logic       i_b0,
  input  logic [3:0] i_y,
  output logic [3:0] o_match
);
  logic [3:0] w_p;
  assign w_p     = {2'b00, i_a1, i_a0} * {2'b00, i_b1, i_b0};
  assign o_match = ~(i_y ^ w_p);
endmodule

module mul4_fitness_scorer #(
  parameter  int LANES     = 16,
  parameter  int NUM_BEATS = 1,
  localparam int SW        = $clog2(NUM_BEATS*LANES*4+1),
  localparam int LW        = $clog2(NUM_BEATS*LANES+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a1,
  input  logic [LANES-1:0] a0,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b0,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  output logic             score_valid,
  input  logic             score_ready,
  output logic [SW-1:0]    score,
  output logic [LW-1:0]    lanes_ok,
  output logic             perfect
);
  localparam int CW   = $clog2(NUM_BEATS+1);
  localparam int MAXS = NUM_BEATS*LANES*4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_beats;
  logic                    r_s1_vld;
  logic [LANES-1:0][3:0]   r_match, w_match;
  logic [SW-1:0]           r_score, w_pop, w_score_nxt;
  logic [LW-1:0]           r_lanes_ok, w_lanes;
  logic                    r_perfect;
  logic                    w_accept, w_enter_run, w_last;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      mul4_fitness_lane u_lane (
        .i_a1   (a1[gi]),
        .i_a0   (a0[gi]),
        .i_b1   (b1[gi]),
        .i_b0   (b0[gi]),
        .i_y    ({y3[gi], y2[gi], y1[gi], y0[gi]}),
        .o_match(w_match[gi])
      );
    end
  endgenerate

  assign in_ready    = (r_state == S_RUN) && (r_beats < CW'(NUM_BEATS));
  assign busy        = (r_state != S_IDLE);
  assign score_valid = (r_state == S_DONE);
  assign score       = r_score;
  assign lanes_ok    = r_lanes_ok;
  assign perfect     = r_perfect;

  assign w_accept    = in_valid && in_ready;
  assign w_enter_run = (r_state == S_IDLE) && start;
  // Beats are accepted in order, so a full counter plus a valid S1 means the
  // last beat is about to be accumulated.
  assign w_last      = (r_state == S_RUN) && r_s1_vld && (r_beats == CW'(NUM_BEATS));

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (score_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Accepted-beat counter, cleared on entry to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_beats <= '0;
    else if (w_enter_run) r_beats <= '0;
    else if (w_accept)    r_beats <= r_beats + 1'b1;
  end

  // S1: capture per-lane match vectors of the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_match  <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) r_match <= w_match;
    end
  end

  // Popcount of matching bits and count of fully correct lanes in S1.
  always_comb begin
    w_pop   = '0;
    w_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < 4; j++) w_pop = w_pop + SW'(r_match[i][j]);
      w_lanes = w_lanes + LW'(&r_match[i]);
    end
  end

  assign w_score_nxt = r_score + w_pop;

  // S2: accumulate; perfect tracks the updated score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score    <= '0;
      r_lanes_ok <= '0;
      r_perfect  <= 1'b0;
    end else if (w_enter_run) begin
      r_score    <= '0;
      r_lanes_ok <= '0;
      r_perfect  <= 1'b0;
    end else if (r_s1_vld) begin
      r_score    <= w_score_nxt;
      r_lanes_ok <= r_lanes_ok + w_lanes;
      r_perfect  <= (w_score_nxt == SW'(MAXS));
    end
  end
endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench: one-beat and two-beat scorer instances sharing stimulus.
module tb_mul4_fitness_scorer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start2, in_valid, score_ready;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic        bz1, ir1, sv1, pf1, bz2, ir2, sv2, pf2;
  logic [6:0]  sc1;
  logic [4:0]  lo1;
  logic [7:0]  sc2;
  logic [5:0]  lo2;
  int          checks = 0;
  int          failures = 0;

  // Exact products for the exhaustive stimulus (lane i: a=i[1:0], b=i[3:2]).
  localparam logic [15:0] G3 = 16'h8000, G2 = 16'h4C00, G1 = 16'h6AC0, G0 = 16'hA0A0;

  always #5 clk = ~clk;

  mul4_fitness_scorer #(.LANES(16), .NUM_BEATS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(bz1),
    .in_valid(in_valid), .in_ready(ir1),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .score_valid(sv1), .score_ready(score_ready),
    .score(sc1), .lanes_ok(lo1), .perfect(pf1));

  mul4_fitness_scorer #(.LANES(16), .NUM_BEATS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(bz2),
    .in_valid(in_valid), .in_ready(ir2),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .score_valid(sv2), .score_ready(score_ready),
    .score(sc2), .lanes_ok(lo2), .perfect(pf2));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_y(input logic [15:0] v3, v2, v1, v0);
    y3 = v3; y2 = v2; y1 = v1; y0 = v0;
  endtask

  // One evaluation on the single-beat instance; hold>0 stalls score_ready.
  task automatic run1(input string t, input int exp_sc, input int exp_lo,
                      input logic exp_pf, input int hold);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk({t, "_busy"}, bz1, 1);
    chk({t, "_ready"}, ir1, 1);
    in_valid = 1'b1; tick();
    chk({t, "_ready_full"}, ir1, 0);
    chk({t, "_sv_lat1"}, sv1, 0);
    tick(); in_valid = 1'b0;
    chk({t, "_sv_lat2"}, sv1, 1);
    chk({t, "_score"}, sc1, exp_sc);
    chk({t, "_lanes_ok"}, lo1, exp_lo);
    chk({t, "_perfect"}, pf1, exp_pf);
    for (int k = 0; k < hold; k++) begin
      start1 = 1'b1; in_valid = 1'b1; tick();
      chk({t, "_hold_sv"}, sv1, 1);
      chk({t, "_hold_score"}, sc1, exp_sc);
      chk({t, "_hold_lanes"}, lo1, exp_lo);
      chk({t, "_hold_perfect"}, pf1, exp_pf);
    end
    start1 = 1'b0; in_valid = 1'b0;
    score_ready = 1'b1; tick(); score_ready = 1'b0;
    chk({t, "_idle_busy"}, bz1, 0);
    chk({t, "_idle_sv"}, sv1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; in_valid = 1'b0; score_ready = 1'b0;
    a0 = 16'hAAAA; a1 = 16'hCCCC; b0 = 16'hF0F0; b1 = 16'hFF00;
    set_y(G3, G2, G1, G0);
    tick(); tick();
    chk("rst_busy1", bz1, 0);
    chk("rst_ready1", ir1, 0);
    chk("rst_sv1", sv1, 0);
    chk("rst_score1", sc1, 0);
    chk("rst_lanes1", lo1, 0);
    chk("rst_perfect1", pf1, 0);
    chk("rst_sv2", sv2, 0);
    rst_n = 1'b1; tick();

    // in_valid while idle must be ignored.
    in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    chk("idle_ignore_busy", bz1, 0);

    // T1 with T4 stall folded in (start/in_valid pulsed during DONE).
    run1("t1", 64, 16, 1'b1, 5);
    // T2: all-zero candidate.
    set_y(16'h0, 16'h0, 16'h0, 16'h0);
    run1("t2", 50, 7, 1'b0, 0);
    // T3: inverted golden.
    set_y(~G3, ~G2, ~G1, ~G0);
    run1("t3", 0, 0, 1'b0, 0);

    // T5: two back-to-back beats on the two-beat instance.
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("t5_ready_b1", ir2, 1);
    set_y(G3, G2, G1, G0); in_valid = 1'b1; tick();
    chk("t5_ready_b2", ir2, 1);
    set_y(16'h0, 16'h0, 16'h0, 16'h0); tick(); in_valid = 1'b0;
    chk("t5_ready_full", ir2, 0);
    chk("t5_sv_lat1", sv2, 0);
    tick();
    chk("t5_sv_lat2", sv2, 1);
    chk("t5_score", sc2, 114);
    chk("t5_lanes_ok", lo2, 23);
    chk("t5_perfect", pf2, 0);
    score_ready = 1'b1; tick(); score_ready = 1'b0;
    chk("t5_idle_busy", bz2, 0);

    // T6: reset after one beat of a two-beat evaluation.
    start2 = 1'b1; tick(); start2 = 1'b0;
    set_y(G3, G2, G1, G0); in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick();
    chk("t6_partial_score", sc2, 64);
    chk("t6_partial_busy", bz2, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_score", sc2, 0);
    chk("t6_rst_lanes", lo2, 0);
    chk("t6_rst_busy", bz2, 0);
    chk("t6_rst_ready", ir2, 0);
    chk("t6_rst_sv", sv2, 0);
    chk("t6_rst_perfect", pf2, 0);
    tick(); rst_n = 1'b1; tick();
    run1("t6_rerun", 64, 16, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
